// File: rtl/ifft_data_input_handler_pkg.sv
// Shared definitions for the IFFT input/output stream handlers:
// default frame geometry, FSM encoding and the complex word packer.
package ifft_data_input_handler_pkg;

   localparam int FRAME_LEN_DEF  = 64;
   localparam int FIFO_DEPTH_DEF = 128;

   typedef enum logic {
      IDLE   = 1'b0,
      STREAM = 1'b1
   } state_t;

   // Real sample in [15:0], imaginary part forced to zero
   function automatic logic [31:0] pack(input logic [15:0] sample);
      return {16'h0000, sample};
   endfunction

endpackage

// File: rtl/ifft_data_input_handler_sample_fifo.sv
// Sample FIFO: register array, first-word-fall-through head, occupancy count.
// Writes while full and reads while empty are ignored.
module ifft_data_input_handler_sample_fifo #(
   parameter int DEPTH = 8,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = $clog2(DEPTH) + 1
) (
   input  logic          CLK,
   input  logic          RST_N,
   input  logic          wr_en_i,
   input  logic [15:0]   wr_data_i,
   input  logic          rd_en_i,
   output logic [15:0]   head_o,
   output logic [CW-1:0] count_o,
   output logic          full_o,
   output logic          empty_o
);

   logic [15:0]   mem [DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0] count_q, count_d;
   logic          push, pop;

   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign push    = wr_en_i && !full_o;
   assign pop     = rd_en_i && !empty_o;
   assign head_o  = mem[rd_ptr_q];
   assign count_o = count_q;

   // Occupancy tracks push/pop; simultaneous push and pop leaves it unchanged
   always_comb begin
      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // Storage array carries no reset; only pointers and count define contents
   always_ff @(posedge CLK) begin
      if (push) mem[wr_ptr_q] <= wr_data_i;
   end

   // Pointers wrap naturally because DEPTH is a power of two
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/ifft_data_input_handler.sv
// IFFT input handler: buffers real samples and streams them to the IFFT
// core as AXI4-Stream frames, starting a frame only once it is fully buffered.
module ifft_data_input_handler
   import ifft_data_input_handler_pkg::*;
#(
   parameter int FRAME_LEN  = FRAME_LEN_DEF,
   parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic [15:0] val,
   input  logic        valStrobe,
   output logic [31:0] tData,
   output logic        tValid,
   output logic        tLast,
   input  logic        tReady,
   output logic        overflow,
   output logic        busy
);

   localparam int IW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   state_t        state_q;
   logic [IW-1:0] idx_q;
   logic          overflow_q;
   logic [15:0]   head;
   logic [CW-1:0] count;
   logic          full, empty;
   logic          last_beat;

   ifft_data_input_handler_sample_fifo #(.DEPTH(FIFO_DEPTH)) u_sample_fifo (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .wr_en_i   (valStrobe),
      .wr_data_i (val),
      .rd_en_i   (tValid && tReady),
      .head_o    (head),
      .count_o   (count),
      .full_o    (full),
      .empty_o   (empty)
   );

   // All stream outputs come from registers only, never from tReady
   assign last_beat = (idx_q == IW'(FRAME_LEN - 1));
   assign tValid    = (state_q == STREAM);
   assign busy      = tValid;
   assign tLast     = tValid && last_beat;
   assign tData     = tValid ? pack(head) : 32'h0;
   assign overflow  = overflow_q;

   // Frame sequencer: wait for a full frame, then stream FRAME_LEN beats
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= IDLE;
         idx_q   <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               idx_q <= '0;
               if (count >= CW'(FRAME_LEN)) state_q <= STREAM;
            end
            STREAM: begin
               if (tReady) begin
                  if (last_beat) begin
                     idx_q   <= '0;
                     state_q <= IDLE;
                  end else begin
                     idx_q <= idx_q + IW'(1);
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Sticky drop flag: full is judged before any same-cycle pop
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N)                overflow_q <= 1'b0;
      else if (valStrobe && full) overflow_q <= 1'b1;
   end

endmodule

// File: tb/tb_ifft_data_input_handler.sv
// Bench for ifft_data_input_handler (FRAME_LEN=4, FIFO_DEPTH=8): directed
// scenarios plus random traffic against a queue-based reference model.
module tb_ifft_data_input_handler;

   localparam int FL = 4;
   localparam int FD = 8;

   logic        CLK = 1'b0;
   logic        RST_N;
   logic [15:0] val;
   logic        valStrobe;
   logic [31:0] tData;
   logic        tValid, tLast, tReady, overflow, busy;

   int checks = 0;
   int errors = 0;

   // Reference model state
   logic [15:0] q[$];
   int          popped;
   logic        exp_valid;
   logic        exp_ovf;

   ifft_data_input_handler #(.FRAME_LEN(FL), .FIFO_DEPTH(FD)) dut (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .val       (val),
      .valStrobe (valStrobe),
      .tData     (tData),
      .tValid    (tValid),
      .tLast     (tLast),
      .tReady    (tReady),
      .overflow  (overflow),
      .busy      (busy)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      q.delete();
      popped    = 0;
      exp_valid = 1'b0;
      exp_ovf   = 1'b0;
   endtask

   // One clock cycle: drive at negedge, check before posedge, update model at posedge
   task automatic cyc(input logic s, input logic [15:0] v, input logic r);
      int   pre;
      logic hs, last;
      valStrobe = s; val = v; tReady = r;
      #1;
      chk("tValid", 32'(tValid), 32'(exp_valid));
      chk("busy", 32'(busy), 32'(exp_valid));
      chk("overflow", 32'(overflow), 32'(exp_ovf));
      if (exp_valid) begin
         chk("tData", tData, {16'h0000, q[0]});
         chk("tLast", 32'(tLast), 32'(popped % FL == FL - 1));
      end else begin
         chk("tLast_idle", 32'(tLast), 32'h0);
      end
      @(posedge CLK);
      pre  = q.size();
      hs   = exp_valid && r;
      last = (popped % FL == FL - 1);
      if (hs) begin
         void'(q.pop_front());
         popped++;
      end
      if (s) begin
         if (pre == FD) exp_ovf = 1'b1;
         else           q.push_back(v);
      end
      if (exp_valid) begin
         if (hs && last) exp_valid = 1'b0;
      end else if (pre >= FL) begin
         exp_valid = 1'b1;
      end
      @(negedge CLK);
   endtask

   task automatic idle(input int n, input logic r);
      for (int i = 0; i < n; i++) cyc(1'b0, 16'h0, r);
   endtask

   logic [15:0] s4 [10] = '{16'h8000, 16'h7FFF, 16'h0001, 16'hFFFF, 16'h1234,
                            16'hABCD, 16'h0000, 16'h5555, 16'hDEAD, 16'hBEEF};

   initial begin
      RST_N = 1'b0; val = '0; valStrobe = 1'b0; tReady = 1'b0;
      model_reset();
      #3;
      chk("rst_tValid", 32'(tValid), 32'h0);
      chk("rst_tLast", 32'(tLast), 32'h0);
      chk("rst_tData", tData, 32'h0);
      chk("rst_overflow", 32'(overflow), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      @(negedge CLK);
      RST_N = 1'b1;

      // Basic frame 1..4 with tReady high
      for (int i = 1; i <= 4; i++) cyc(1'b1, 16'(i), 1'b1);
      idle(8, 1'b1);

      // Three samples wait indefinitely; a fourth starts the frame
      for (int i = 0; i < 3; i++) cyc(1'b1, 16'(16'h10 + i), 1'b1);
      idle(10, 1'b1);
      cyc(1'b1, 16'h0013, 1'b1);
      idle(8, 1'b1);

      // Stalled frame with tReady pattern 1,0,0,1
      for (int i = 0; i < 4; i++) cyc(1'b1, 16'(16'h20 + i), 1'b0);
      for (int i = 0; i < 16; i++) cyc(1'b0, 16'h0, (i % 4 == 0) || (i % 4 == 3));
      idle(4, 1'b1);

      // Fill to capacity with tReady low, two more writes are dropped
      for (int i = 0; i < 10; i++) cyc(1'b1, s4[i], 1'b0);
      idle(14, 1'b1);

      // Reset after the second beat of a frame
      for (int i = 0; i < 4; i++) cyc(1'b1, 16'(16'h40 + i), 1'b0);
      cyc(1'b0, 16'h0, 1'b0);
      cyc(1'b0, 16'h0, 1'b1);
      cyc(1'b0, 16'h0, 1'b1);
      #2 RST_N = 1'b0;
      #1;
      chk("midrst_tValid", 32'(tValid), 32'h0);
      chk("midrst_tLast", 32'(tLast), 32'h0);
      chk("midrst_busy", 32'(busy), 32'h0);
      chk("midrst_overflow", 32'(overflow), 32'h0);
      model_reset();
      @(negedge CLK);
      RST_N = 1'b1;
      idle(3, 1'b1);
      for (int i = 0; i < 4; i++) cyc(1'b1, 16'(16'h50 + i), 1'b1);
      idle(8, 1'b1);

      // Seven queued, then write and handshake in the same cycle
      for (int i = 0; i < 7; i++) cyc(1'b1, 16'(16'h60 + i), 1'b0);
      cyc(1'b1, 16'h0067, 1'b1);
      idle(16, 1'b1);

      // Random traffic
      for (int i = 0; i < 800; i++)
         cyc(($urandom % 3) != 0, 16'($urandom), ($urandom % 4) != 0);
      idle(24, 1'b1);
      chk("drain_empty", 32'(q.size()), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
